hazard_stall_ctrl: RTL and testbench

- Producer-side counterpart to the EX-stage forwarding logic. It detects every RAW hazard that forwarding cannot cover and stalls or bubbles the pipeline until the operand reaches a forwardable point.
  - EX/MEM forwarding covers only WB_ALU results; non-ALU results (load, PC+4) are forwarded only from MEM/WB.
- It also sequences multi-cycle P-extension ops occupying EX, and flushes on taken branch/jump.
- Sits beside the pipeline registers and drives their enable/clear lines. Keeps wrap-around performance counters.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/mc_seq_counter.sv | 61 ++++++
 rtl/hazard_stall_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types: writeback source select plus hazard/stall controller state.
package rv32_pkg;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } WBSel_t;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } HZ_STATE_t;

    localparam int HZ_MC_LATENCY_DEF = 4;

endpackage

// File: rtl/mc_seq_counter.sv
// Multi-cycle EX occupancy sequencer: holds the front of the pipe while a
// P-extension op spends MC_LATENCY cycles in EX, flagging the final cycle.
module mc_seq_counter
    import rv32_pkg::*;
#(
    parameter int MC_LATENCY = HZ_MC_LATENCY_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic mc_start_i,
    output logic mc_stall_o,
    output logic mc_busy_o,
    output logic mc_done_o
);

    localparam int CNT_W = $clog2(MC_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);

    HZ_STATE_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first EX cycle is spent in IDLE, so BUSY only counts the remaining ones.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_stall_o = 1'b0;
        mc_done_o  = 1'b0;
        unique case (state_q)
            HZ_IDLE: begin
                if (mc_start_i) begin
                    mc_stall_o = 1'b1;
                    state_d    = HZ_BUSY;
                    cnt_d      = CNT_LOAD;
                end
            end
            HZ_BUSY: begin
                if (cnt_q == '0) begin
                    mc_done_o = 1'b1;
                    state_d   = HZ_IDLE;
                end else begin
                    mc_stall_o = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = HZ_IDLE;
        endcase
    end

    assign mc_busy_o = (state_q == HZ_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for RAW hazards forwarding cannot cover, multi-cycle EX
// ops and taken branches; drives pipeline register enables and keeps perf counters.
module hazard_stall_ctrl
    import rv32_pkg::*;
#(
    parameter int MC_LATENCY = HZ_MC_LATENCY_DEF,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        rs1_ID,
    input  logic [4:0]        rs2_ID,
    input  logic              rs1_used_ID,
    input  logic              rs2_used_ID,
    input  logic              RegWEn_EX,
    input  WBSel_t            WBSel_EX,
    input  logic [4:0]        rd_EX,
    input  logic              RegWEn_MEM,
    input  WBSel_t            WBSel_MEM,
    input  logic [4:0]        rd_MEM,
    input  logic              br_taken_EX,
    input  logic              mc_start_EX,
    output logic              stall_PC,
    output logic              stall_IFID,
    output logic              stall_IDEX,
    output logic              flush_IFID,
    output logic              bubble_IDEX,
    output logic              bubble_EXMEM,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
);

    logic mc_stall;
    logic hz_EX, hz_MEM, hz;
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

    function automatic logic match_id(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic use1,
                                      input logic use2);
        return (rd != 5'd0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
    endfunction

    mc_seq_counter #(
        .MC_LATENCY(MC_LATENCY)
    ) u_mc_seq (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .mc_start_i(mc_start_EX),
        .mc_stall_o(mc_stall),
        .mc_busy_o (mc_busy),
        .mc_done_o (mc_done)
    );

    // Only ALU results are forwardable from EX/MEM; loads and PC+4 must reach MEM/WB.
    assign hz_EX  = RegWEn_EX && (WBSel_EX != WB_ALU)
                    && match_id(rd_EX, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID);
    assign hz_MEM = RegWEn_MEM && (WBSel_MEM != WB_ALU)
                    && match_id(rd_MEM, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID);
    assign hz     = hz_EX || hz_MEM;

    always_comb begin
        stall_PC     = 1'b0;
        stall_IFID   = 1'b0;
        stall_IDEX   = 1'b0;
        flush_IFID   = 1'b0;
        bubble_IDEX  = 1'b0;
        bubble_EXMEM = 1'b0;
        if (mc_stall) begin
            stall_PC     = 1'b1;
            stall_IFID   = 1'b1;
            stall_IDEX   = 1'b1;
            bubble_EXMEM = 1'b1;
        end else if (br_taken_EX) begin
            // The ID instruction is squashed, so any hazard it carries is moot.
            flush_IFID  = 1'b1;
            bubble_IDEX = 1'b1;
        end else if (hz) begin
            stall_PC    = 1'b1;
            stall_IFID  = 1'b1;
            bubble_IDEX = 1'b1;
        end
    end

    assign perf_stall_d = stall_PC   ? perf_stall_q + PERF_W'(1) : perf_stall_q;
    assign perf_flush_d = flush_IFID ? perf_flush_q + PERF_W'(1) : perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios then random traffic
// against a behavioural model tracking op phase and register read sets.
module tb_hazard_stall_ctrl;
    import rv32_pkg::*;

    localparam int ML   = 4;
    localparam int PW   = 6;
    localparam int MASK = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_ID, rs2_ID, rd_EX, rd_MEM;
    logic          rs1_used_ID, rs2_used_ID, RegWEn_EX, RegWEn_MEM;
    WBSel_t        WBSel_EX, WBSel_MEM;
    logic          br_taken_EX, mc_start_EX;
    logic          stall_PC, stall_IFID, stall_IDEX, flush_IFID;
    logic          bubble_IDEX, bubble_EXMEM, mc_busy, mc_done;
    logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: phase = cycles the current multi-cycle op has already spent in EX (-1: none)
    int phase = -1;
    int m_stall = 0;
    int m_flush = 0;
    int cur_ph;
    logic e_stall, e_flush;

    hazard_stall_ctrl #(.MC_LATENCY(ML), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX), .rd_EX(rd_EX),
        .RegWEn_MEM(RegWEn_MEM), .WBSel_MEM(WBSel_MEM), .rd_MEM(rd_MEM),
        .br_taken_EX(br_taken_EX), .mc_start_EX(mc_start_EX),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX),
        .flush_IFID(flush_IFID), .bubble_IDEX(bubble_IDEX), .bubble_EXMEM(bubble_EXMEM),
        .mc_busy(mc_busy), .mc_done(mc_done),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
        RegWEn_EX = 1'b0; WBSel_EX = WB_ALU; rd_EX = 5'd0;
        RegWEn_MEM = 1'b0; WBSel_MEM = WB_ALU; rd_MEM = 5'd0;
        br_taken_EX = 1'b0; mc_start_EX = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sPC"}, 32'(stall_PC), 0);
        chk({tag, ".sIFID"}, 32'(stall_IFID), 0);
        chk({tag, ".sIDEX"}, 32'(stall_IDEX), 0);
        chk({tag, ".flush"}, 32'(flush_IFID), 0);
        chk({tag, ".bIDEX"}, 32'(bubble_IDEX), 0);
        chk({tag, ".bEXMEM"}, 32'(bubble_EXMEM), 0);
        chk({tag, ".busy"}, 32'(mc_busy), 0);
        chk({tag, ".done"}, 32'(mc_done), 0);
        chk({tag, ".pstall"}, 32'(perf_stall_cnt), 0);
        chk({tag, ".pflush"}, 32'(perf_flush_cnt), 0);
    endtask

    // Compare every output at the falling edge against the model.
    task automatic tick(input string tag);
        logic [31:0] reads;
        logic        m_mc, m_done, m_busy, hz;
        logic        x_sPC, x_sIFID, x_sIDEX, x_fl, x_bIDEX, x_bEXMEM;
        @(negedge clk);
        cur_ph = (phase < 0 && mc_start_EX) ? 0 : phase;
        m_mc   = (cur_ph >= 0) && (cur_ph < ML - 1);
        m_done = (cur_ph == ML - 1);
        m_busy = (cur_ph >= 1);
        reads = 32'd0;
        if (rs1_used_ID) reads[rs1_ID] = 1'b1;
        if (rs2_used_ID) reads[rs2_ID] = 1'b1;
        reads[0] = 1'b0;
        hz = (RegWEn_EX && WBSel_EX != WB_ALU && reads[rd_EX])
          || (RegWEn_MEM && WBSel_MEM != WB_ALU && reads[rd_MEM]);
        x_sPC = 0; x_sIFID = 0; x_sIDEX = 0; x_fl = 0; x_bIDEX = 0; x_bEXMEM = 0;
        if (m_mc) begin
            x_sPC = 1; x_sIFID = 1; x_sIDEX = 1; x_bEXMEM = 1;
        end else if (br_taken_EX) begin
            x_fl = 1; x_bIDEX = 1;
        end else if (hz) begin
            x_sPC = 1; x_sIFID = 1; x_bIDEX = 1;
        end
        e_stall = x_sPC;
        e_flush = x_fl;
        chk({tag, ".sPC"}, 32'(stall_PC), 32'(x_sPC));
        chk({tag, ".sIFID"}, 32'(stall_IFID), 32'(x_sIFID));
        chk({tag, ".sIDEX"}, 32'(stall_IDEX), 32'(x_sIDEX));
        chk({tag, ".flush"}, 32'(flush_IFID), 32'(x_fl));
        chk({tag, ".bIDEX"}, 32'(bubble_IDEX), 32'(x_bIDEX));
        chk({tag, ".bEXMEM"}, 32'(bubble_EXMEM), 32'(x_bEXMEM));
        chk({tag, ".busy"}, 32'(mc_busy), 32'(m_busy));
        chk({tag, ".done"}, 32'(mc_done), 32'(m_done));
        chk({tag, ".pstall"}, 32'(perf_stall_cnt), 32'(m_stall & MASK));
        chk({tag, ".pflush"}, 32'(perf_flush_cnt), 32'(m_flush & MASK));
    endtask

    task automatic adv();
        @(posedge clk);
        if (e_stall) m_stall++;
        if (e_flush) m_flush++;
        if (cur_ph == ML - 1)  phase = -1;
        else if (cur_ph >= 0)  phase = cur_ph + 1;
        else                   phase = -1;
        #1;
    endtask

    initial begin
        int s0, f0;
        set_idle();
        rst_n = 1'b0;
        #3;
        chk_all_zero("reset");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use at distance 1: two bubbles
        RegWEn_EX = 1; WBSel_EX = WB_MEM; rd_EX = 5'd5; rs1_ID = 5'd5; rs1_used_ID = 1;
        tick("lu_c0");
        chk("lu_c0.stall_const", 32'(stall_PC), 1);
        chk("lu_c0.bubble_const", 32'(bubble_IDEX), 1);
        adv();
        RegWEn_EX = 0; rd_EX = 5'd0; WBSel_EX = WB_ALU;
        RegWEn_MEM = 1; WBSel_MEM = WB_MEM; rd_MEM = 5'd5;
        tick("lu_c1");
        chk("lu_c1.stall_const", 32'(stall_PC), 1);
        chk("lu_c1.bubble_const", 32'(bubble_IDEX), 1);
        adv();
        RegWEn_MEM = 0; rd_MEM = 5'd0;
        tick("lu_c2");
        chk("lu_c2.stall_const", 32'(stall_PC), 0);
        adv();

        // ALU producer is forwardable
        set_idle();
        s0 = int'(perf_stall_cnt);
        RegWEn_EX = 1; WBSel_EX = WB_ALU; rd_EX = 5'd7; rs2_ID = 5'd7; rs2_used_ID = 1;
        tick("alu");
        chk("alu.stall_const", 32'(stall_PC), 0);
        adv();
        chk("alu.perf_unchanged", 32'(perf_stall_cnt), 32'(s0));

        // x0 producer and unused operand
        set_idle();
        RegWEn_EX = 1; WBSel_EX = WB_MEM; rd_EX = 5'd0; rs1_ID = 5'd0; rs1_used_ID = 1;
        tick("x0");
        chk("x0.stall_const", 32'(stall_PC), 0);
        adv();
        set_idle();
        RegWEn_EX = 1; WBSel_EX = WB_PC4; rd_EX = 5'd9; rs2_ID = 5'd9; rs1_ID = 5'd3;
        rs1_used_ID = 1; rs2_used_ID = 0;
        tick("unused");
        chk("unused.stall_const", 32'(stall_PC), 0);
        adv();

        // Branch beats a MEM-stage hazard
        set_idle();
        f0 = int'(perf_flush_cnt);
        RegWEn_MEM = 1; WBSel_MEM = WB_MEM; rd_MEM = 5'd4; rs1_ID = 5'd4; rs1_used_ID = 1;
        br_taken_EX = 1;
        tick("br");
        chk("br.flush_const", 32'(flush_IFID), 1);
        chk("br.bubble_const", 32'(bubble_IDEX), 1);
        chk("br.stall_const", 32'(stall_PC), 0);
        adv();
        chk("br.perf_flush", 32'(perf_flush_cnt), 32'((f0 + 1) & MASK));

        // Multi-cycle op, held in EX for ML cycles
        set_idle();
        s0 = int'(perf_stall_cnt);
        mc_start_EX = 1;
        for (int i = 0; i < ML; i++) begin
            tick($sformatf("mc%0d", i));
            chk($sformatf("mc%0d.stall_const", i), 32'(stall_PC), 32'(i < ML - 1));
            chk($sformatf("mc%0d.done_const", i), 32'(mc_done), 32'(i == ML - 1));
            chk($sformatf("mc%0d.busy_const", i), 32'(mc_busy), 32'(i >= 1));
            adv();
        end
        mc_start_EX = 0;
        chk("mc.perf_stall", 32'(perf_stall_cnt), 32'((s0 + ML - 1) & MASK));

        // Reset asserted in BUSY cycle 2 acts without a clock edge
        mc_start_EX = 1;
        tick("rmid0"); adv();
        tick("rmid1"); adv();
        #2;
        mc_start_EX = 0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        phase = -1; m_stall = 0; m_flush = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        tick("post_rst");
        adv();

        // Random traffic; small register range keeps matches frequent
        for (int n = 0; n < 400; n++) begin
            rs1_ID      = 5'($urandom_range(0, 3));
            rs2_ID      = 5'($urandom_range(0, 3));
            rs1_used_ID = 1'($urandom_range(0, 1));
            rs2_used_ID = 1'($urandom_range(0, 1));
            RegWEn_EX   = 1'($urandom_range(0, 1));
            WBSel_EX    = WBSel_t'($urandom_range(0, 2));
            rd_EX       = 5'($urandom_range(0, 3));
            RegWEn_MEM  = 1'($urandom_range(0, 1));
            WBSel_MEM   = WBSel_t'($urandom_range(0, 2));
            rd_MEM      = 5'($urandom_range(0, 3));
            br_taken_EX = ($urandom_range(0, 7) == 0);
            mc_start_EX = (phase >= 0) ? 1'b1 : 1'($urandom_range(0, 9) == 0);
            tick($sformatf("rnd%0d", n));
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
